// File: rtl/iot601x_reader_pkg.sv
// rtl/iot601x_reader_pkg.sv - shared constants and types for the 601x paper-tape reader IOT handler
package iot601x_reader_pkg;

  localparam logic [5:0] DEV_CODE = 6'o01;

  localparam int OP_RSF = 0;
  localparam int OP_RRB = 1;
  localparam int OP_RFC = 2;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_WAIT,
    FETCH_LOAD
  } fetch_state_t;

endpackage

// File: rtl/iot601x_reader_byte_fifo.sv
// rtl/iot601x_reader_byte_fifo.sv - DEPTH x 8 byte FIFO with push/pop, full/empty and occupancy count
module iot601x_reader_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [7:0]              din,
  output logic [7:0]              dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/iot601x_reader.sv
// rtl/iot601x_reader.sv - reader IOT handler (601x): UART byte FIFO, fetch FSM, flag/skip/AC load
module iot601x_reader
  import iot601x_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        clear,
  input  logic        EN,
  input  logic [2:0]  IR,
  input  logic        ck1,
  input  logic        ck2,
  input  logic        ck3,
  input  logic        ck4,
  input  logic        ck5,
  input  logic        ck6,
  input  logic        stb1,
  input  logic        stb2,
  input  logic        stb3,
  input  logic        stb4,
  input  logic        stb5,
  input  logic        stb6,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic [11:0] ACOUT,
  output logic        rot2ac,
  output logic        ac_ck,
  output logic        pc_ck,
  output logic        done,
  output logic        irq,
  output logic        overrun
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [7:0]    buffer;
  logic [7:0]    head;
  logic          flag;
  logic          ie;
  logic          pending;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          load;
  logic          pop;
  logic          push;
  logic          rpe_set;
  logic          rrb_drive;
  logic          rrb_clear;
  logic          rfc_start;
  logic          unused;

  assign unused = &{1'b0, DEV_CODE, ck1, ck4, ck5, stb2, stb5, stb6, count};

  // RFC is ignored while a fetch is already outstanding.
  assign rpe_set   = EN && (IR == 3'b000) && stb1;
  assign rrb_drive = EN && IR[OP_RRB] && ck3;
  assign rrb_clear = EN && IR[OP_RRB] && stb3;
  assign rfc_start = EN && IR[OP_RFC] && stb4 && !pending;

  assign load = (state == FETCH_LOAD);
  assign pop  = load && !clear;
  assign push = rxValid && (!full || pop);

  assign ACOUT  = rrb_drive ? {4'b0000, buffer} : 12'o0000;
  assign rot2ac = rrb_drive;
  assign ac_ck  = rrb_drive;
  assign pc_ck  = EN && IR[OP_RSF] && ck2 && flag;
  assign done   = EN && ck6;
  assign irq    = flag && ie;

  iot601x_reader_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (push),
    .pop   (pop),
    .din   (rxData),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= FETCH_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH_IDLE: if (pending || rfc_start) state_next = FETCH_WAIT;
      FETCH_WAIT: if (!empty) state_next = FETCH_LOAD;
      FETCH_LOAD: state_next = FETCH_IDLE;
      default:    state_next = FETCH_IDLE;
    endcase
    if (clear) state_next = FETCH_IDLE;
  end

  // A LOAD landing on the same edge as an RRB/RFC flag clear leaves the flag set.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      buffer  <= 8'h00;
      flag    <= 1'b0;
      ie      <= 1'b1;
      pending <= 1'b0;
    end else if (clear) begin
      buffer  <= 8'h00;
      flag    <= 1'b0;
      ie      <= 1'b1;
      pending <= 1'b0;
    end else begin
      if (rpe_set) ie <= 1'b1;
      if (load) begin
        buffer  <= head;
        flag    <= 1'b1;
        pending <= 1'b0;
      end else begin
        if (rrb_clear || rfc_start) flag <= 1'b0;
        if (rfc_start)              pending <= 1'b1;
      end
    end
  end

  // Overrun survives CLEAR; only a hard reset drops it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                     overrun <= 1'b0;
    else if (rxValid && full && !pop) overrun <= 1'b1;
  end

endmodule

// File: tb/tb_iot601x_reader.sv
// tb/tb_iot601x_reader.sv - self-checking bench for iot601x_reader
module tb_iot601x_reader;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        clear;
  logic        EN;
  logic [2:0]  IR;
  logic [6:1]  ck;
  logic [6:1]  stb;
  logic [7:0]  rxData;
  logic        rxValid;
  logic [11:0] ACOUT;
  logic        rot2ac;
  logic        ac_ck;
  logic        pc_ck;
  logic        done;
  logic        irq;
  logic        overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of buffered bytes plus architectural reader state.
  logic [7:0] q[$];
  logic [7:0] m_buf;
  logic       m_flag;
  logic       m_pending;
  logic       m_over;

  always #5 CLK = ~CLK;

  iot601x_reader #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .clear(clear), .EN(EN), .IR(IR),
    .ck1(ck[1]), .ck2(ck[2]), .ck3(ck[3]), .ck4(ck[4]), .ck5(ck[5]), .ck6(ck[6]),
    .stb1(stb[1]), .stb2(stb[2]), .stb3(stb[3]), .stb4(stb[4]), .stb5(stb[5]), .stb6(stb[6]),
    .rxData(rxData), .rxValid(rxValid), .ACOUT(ACOUT), .rot2ac(rot2ac), .ac_ck(ac_ck),
    .pc_ck(pc_ck), .done(done), .irq(irq), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    EN = 1'b0; IR = 3'b000; ck = '0; stb = '0;
  endtask

  task automatic model_reset();
    q.delete();
    m_buf = 8'h00; m_flag = 1'b0; m_pending = 1'b0; m_over = 1'b0;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else m_over = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_acout"}, 32'(ACOUT), 32'd0);
    check({tag, "_rot2ac"}, 32'(rot2ac), 32'd0);
    check({tag, "_ac_ck"}, 32'(ac_ck), 32'd0);
    check({tag, "_pc_ck"}, 32'(pc_ck), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_irq"}, 32'(irq), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  task automatic settle();
    repeat (4) @(negedge CLK);
    if (m_pending && q.size() > 0) begin
      m_buf = q.pop_front();
      m_flag = 1'b1;
      m_pending = 1'b0;
    end
    #1;
    check("settle_irq", 32'(irq), 32'(m_flag));
    check("settle_overrun", 32'(overrun), 32'(m_over));
  endtask

  task automatic push_byte(input logic [7:0] b, input bit do_settle);
    @(negedge CLK); rxData = b; rxValid = 1'b1;
    @(negedge CLK); rxValid = 1'b0;
    model_push(b);
    if (do_settle) settle();
  endtask

  task automatic run_iot(input logic [2:0] op);
    logic [11:0] exp_ac;
    logic        exp_pc;
    exp_ac = op[1] ? {4'b0000, m_buf} : 12'o0000;
    exp_pc = op[0] && m_flag;
    for (int ph = 1; ph <= 6; ph++) begin
      for (int s = 0; s < 2; s++) begin
        @(negedge CLK);
        EN = 1'b1; IR = op;
        ck = 6'b000001 << (ph - 1);
        stb = (s == 1) ? ck : 6'b000000;
        #1;
        if (ph == 2) check("rsf_pc_ck", 32'(pc_ck), 32'(exp_pc));
        if (ph == 3) begin
          check("rrb_acout", 32'(ACOUT), 32'(exp_ac));
          check("rrb_ac_ck", 32'(ac_ck & rot2ac), 32'(op[1]));
        end else begin
          check("acout_idle", 32'(ACOUT), 32'd0);
        end
        check("done", 32'(done), 32'(ph == 6));
        if (ph == 4 && s == 0 && op[1]) check("rrb_flag_clear", 32'(irq), 32'd0);
      end
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    check("done_end", 32'(done), 32'd0);
    if (op[1]) m_flag = 1'b0;
    if (op[2] && !m_pending) begin
      m_flag = 1'b0;
      m_pending = 1'b1;
    end
    settle();
  endtask

  task automatic clear_pulse();
    @(negedge CLK); clear = 1'b1;
    @(negedge CLK); clear = 1'b0;
    m_flag = 1'b0; m_buf = 8'h00; m_pending = 1'b0;
    #1;
    check("clear_irq", 32'(irq), 32'd0);
  endtask

  task automatic rfc_pulse();
    @(negedge CLK); EN = 1'b1; IR = 3'b100; ck[4] = 1'b1; stb[4] = 1'b1;
    @(negedge CLK); idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; clear = 1'b0; rxData = 8'h00; rxValid = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge CLK);
    #1;
    check_quiet("reset");
    @(negedge CLK); RESET_N = 1'b1;

    // Basic read with cycle-exact flag timing.
    push_byte(8'h41, 1'b1);
    rfc_pulse();
    #1 check("rfc_t0", 32'(irq), 32'd0);
    @(negedge CLK); #1 check("rfc_t1", 32'(irq), 32'd0);
    @(negedge CLK); #1 check("rfc_t2", 32'(irq), 32'd1);
    m_buf = q.pop_front(); m_flag = 1'b1; m_pending = 1'b0;
    run_iot(3'b001);
    run_iot(3'b010);
    check("basic_flag_cleared", 32'(irq), 32'd0);

    // Overflow: fifth byte dropped, four reads come back in order across the pointer wrap.
    for (int i = 1; i <= 5; i++) push_byte(8'(i), 1'b0);
    #1 check("overrun_set", 32'(overrun), 32'd1);
    for (int i = 0; i < 4; i++) begin
      run_iot(3'b100);
      run_iot(3'b010);
    end

    // Hard reset while the fetch FSM sits in LOAD.
    push_byte(8'h55, 1'b0);
    rfc_pulse();
    @(negedge CLK);
    #1 RESET_N = 1'b0;
    #1 check_quiet("reset_mid_load");
    model_reset();
    @(negedge CLK); @(negedge CLK); RESET_N = 1'b1;
    run_iot(3'b001);
    run_iot(3'b010);

    // RFC on an empty FIFO waits for the next received byte.
    run_iot(3'b100);
    repeat (50) @(negedge CLK);
    #1 check("empty_wait", 32'(irq), 32'd0);
    @(negedge CLK); rxData = 8'hFF; rxValid = 1'b1;
    @(negedge CLK); rxValid = 1'b0;
    #1 check("push_t0", 32'(irq), 32'd0);
    @(negedge CLK); #1 check("push_t1", 32'(irq), 32'd0);
    @(negedge CLK); #1 check("push_t2", 32'(irq), 32'd1);
    m_buf = 8'hFF; m_flag = 1'b1; m_pending = 1'b0;
    run_iot(3'b010);

    // Interrupt and CLEAR keeping FIFO contents.
    push_byte(8'h5A, 1'b1);
    push_byte(8'h6B, 1'b1);
    run_iot(3'b100);
    check("irq_set", 32'(irq), 32'd1);
    clear_pulse();
    run_iot(3'b100);
    run_iot(3'b010);

    // Combined 6016: read current byte, then fetch the next.
    push_byte(8'h12, 1'b1);
    run_iot(3'b100);
    push_byte(8'h34, 1'b1);
    run_iot(3'b110);
    check("combined_reload", 32'(m_buf), 32'h34);
    run_iot(3'b010);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    push_byte(8'($urandom_range(0, 255)), 1'b1);
        2:       run_iot(3'b100);
        3:       run_iot(3'b010);
        4:       run_iot(3'b001);
        5:       run_iot(3'b110);
        6:       run_iot(3'($urandom_range(0, 7)));
        default: clear_pulse();
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
